// File: rtl/axi_host_master.sv
// Single-outstanding command-to-AXI-lite initiator. A registered FSM turns one
// command into a write or read handshake and bounds each transaction with a timeout.
module axi_host_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] Write_Address_axi,
  output logic [DATA_W-1:0] Write_Data_axi,
  output logic [3:0]        Write_Strobe,
  output logic [2:0]        W_Prot,
  output logic              Write_Valid,
  input  logic              Write_Ready,
  input  logic              W_Error,
  output logic              R_Valid_Address,
  output logic [ADDR_W-1:0] Read_Address_axi,
  output logic [2:0]        R_Prot,
  input  logic              R_Ready_Address,
  output logic              Read_Ready,
  input  logic              Valid_Data_R,
  input  logic [DATA_W-1:0] Read_Data_axi,
  input  logic              R_Error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_C = TIMEOUT_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                timeout_hit;

  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [3:0]          wr_strb_q, wr_strb_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_valid_addr_q, rd_valid_addr_d;
  logic                rd_ready_q, rd_ready_d;

  logic [DATA_W-1:0]   lat_rdata_q, lat_rdata_d;
  logic                lat_err_q, lat_err_d;
  logic                lat_to_q, lat_to_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      cmd_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      wr_strb_q       <= '0;
      wr_valid_q      <= 1'b0;
      rd_addr_q       <= '0;
      rd_valid_addr_q <= 1'b0;
      rd_ready_q      <= 1'b0;
      lat_rdata_q     <= '0;
      lat_err_q       <= 1'b0;
      lat_to_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cmd_ready_q     <= cmd_ready_d;
      busy_q          <= busy_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
      rsp_timeout_q   <= rsp_timeout_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      wr_strb_q       <= wr_strb_d;
      wr_valid_q      <= wr_valid_d;
      rd_addr_q       <= rd_addr_d;
      rd_valid_addr_q <= rd_valid_addr_d;
      rd_ready_q      <= rd_ready_d;
      lat_rdata_q     <= lat_rdata_d;
      lat_err_q       <= lat_err_d;
      lat_to_q        <= lat_to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    rd_addr_d   = rd_addr_q;
    lat_rdata_d = lat_rdata_q;
    lat_err_d   = lat_err_q;
    lat_to_d    = lat_to_q;
    timeout_hit = 1'b0;
    cnt_inc     = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + TIMEOUT_W'(1);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d       = '0;
          lat_rdata_d = '0;
          lat_err_d   = 1'b0;
          lat_to_d    = 1'b0;
          if (cmd_write) begin
            wr_addr_d = cmd_addr;
            wr_data_d = cmd_wdata;
            wr_strb_d = cmd_strb;
            state_d   = WR_REQ;
          end else begin
            rd_addr_d = cmd_addr;
            state_d   = RD_ADDR;
          end
        end
      end
      // A handshake on the same edge the counter expires still counts as a transfer.
      WR_REQ: begin
        cnt_d = cnt_inc;
        if (Write_Ready) begin
          lat_err_d = W_Error;
          state_d   = RESP;
        end else if (cnt_inc == TIMEOUT_C) begin
          timeout_hit = 1'b1;
        end
      end
      RD_ADDR: begin
        cnt_d = cnt_inc;
        if (R_Ready_Address) begin
          state_d = RD_DATA;
        end else if (cnt_inc == TIMEOUT_C) begin
          timeout_hit = 1'b1;
        end
      end
      RD_DATA: begin
        cnt_d = cnt_inc;
        if (Valid_Data_R) begin
          lat_rdata_d = Read_Data_axi;
          lat_err_d   = R_Error;
          state_d     = RESP;
        end else if (cnt_inc == TIMEOUT_C) begin
          timeout_hit = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      state_d     = RESP;
      lat_rdata_d = '0;
      lat_err_d   = 1'b1;
      lat_to_d    = 1'b1;
    end

    // Bus strobes follow the next state; the response pulse trails the RESP state.
    wr_valid_d      = (state_d == WR_REQ);
    rd_valid_addr_d = (state_d == RD_ADDR);
    rd_ready_d      = (state_d == RD_DATA);
    cmd_ready_d     = (state_d == IDLE);
    busy_d          = (state_d != IDLE);
    rsp_valid_d     = (state_q == RESP);
    rsp_rdata_d     = (state_q == RESP) ? lat_rdata_q : '0;
    rsp_err_d       = (state_q == RESP) && lat_err_q;
    rsp_timeout_d   = (state_q == RESP) && lat_to_q;
  end

  assign cmd_ready         = cmd_ready_q;
  assign busy              = busy_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_err           = rsp_err_q;
  assign rsp_timeout       = rsp_timeout_q;
  assign Write_Address_axi = wr_addr_q;
  assign Write_Data_axi    = wr_data_q;
  assign Write_Strobe      = wr_strb_q;
  assign W_Prot            = 3'b000;
  assign Write_Valid       = wr_valid_q;
  assign R_Valid_Address   = rd_valid_addr_q;
  assign Read_Address_axi  = rd_addr_q;
  assign R_Prot            = 3'b000;
  assign Read_Ready        = rd_ready_q;

endmodule

// File: tb/tb_axi_host_master.sv
// Bench for axi_host_master: directed and random transactions against a
// transaction-level model of handshake counts, latency and response contents.
module tb_axi_host_master;

  localparam int TIMEOUT = 255;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] Write_Address_axi, Write_Data_axi;
  logic [3:0]  Write_Strobe;
  logic [2:0]  W_Prot, R_Prot;
  logic        Write_Valid, Write_Ready, W_Error;
  logic        R_Valid_Address, R_Ready_Address, Read_Ready, Valid_Data_R, R_Error;
  logic [31:0] Read_Address_axi, Read_Data_axi;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          hold_en  = 1'b0;
  logic [31:0] hold_addr = '0;
  int          last_wait = 0;

  always #5 Clk = ~Clk;

  axi_host_master dut (
    .Clk(Clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .Write_Address_axi(Write_Address_axi), .Write_Data_axi(Write_Data_axi),
    .Write_Strobe(Write_Strobe), .W_Prot(W_Prot), .Write_Valid(Write_Valid),
    .Write_Ready(Write_Ready), .W_Error(W_Error),
    .R_Valid_Address(R_Valid_Address), .Read_Address_axi(Read_Address_axi),
    .R_Prot(R_Prot), .R_Ready_Address(R_Ready_Address), .Read_Ready(Read_Ready),
    .Valid_Data_R(Valid_Data_R), .Read_Data_axi(Read_Data_axi), .R_Error(R_Error)
  );

  // Runs one transaction with a slave that accepts after d1 (address/write) and
  // d2 (read data) waiting cycles, then compares against the expected outcome.
  task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int d1, input int d2, input bit serr,
                         input logic [31:0] sdata);
    bit          ok, hold;
    int          exp_wv, exp_rva, exp_rr, exp_lat;
    logic        exp_err, exp_to;
    logic [31:0] exp_rdata, got_rdata;
    logic        got_err, got_to;
    int          wv_n, rva_n, rr_n, rsp_n, rsp_k, wait_n;
    int          stable_bad, overlap_bad, busy_bad;

    hold = hold_en;
    if (wr) begin
      ok      = (strb == 4'hF) && (d1 <= TIMEOUT - 1);
      exp_wv  = ok ? d1 + 1 : TIMEOUT;
      exp_rva = 0;
      exp_rr  = 0;
      exp_lat = exp_wv + 2;
    end else begin
      ok      = (d1 + d2 + 2 <= TIMEOUT);
      exp_wv  = 0;
      exp_rva = (d1 + 1 < TIMEOUT) ? d1 + 1 : TIMEOUT;
      exp_rr  = ok ? d2 + 1 : TIMEOUT - exp_rva;
      exp_lat = exp_rva + exp_rr + 2;
    end
    exp_err   = ok ? serr : 1'b1;
    exp_to    = !ok;
    exp_rdata = (ok && !wr) ? sdata : 32'h0;

    wv_n = 0; rva_n = 0; rr_n = 0; rsp_n = 0; rsp_k = 0; wait_n = 0;
    stable_bad = 0; overlap_bad = 0; busy_bad = 0;
    got_rdata = '0; got_err = 1'b0; got_to = 1'b0;

    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && wait_n < 20) begin
      @(negedge Clk);
      wait_n++;
    end
    last_wait = wait_n;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s accept: cmd_ready=%b, required 1 within 20 cycles", name, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    if (hold) begin
      cmd_write = 1'b0;
      cmd_addr  = hold_addr;
    end else begin
      cmd_valid = 1'b0;
    end

    for (int k = 1; k <= 300; k++) begin
      @(negedge Clk);
      if (Write_Valid === 1'b1) begin
        wv_n++;
        if (Write_Address_axi !== addr || Write_Data_axi !== wdata || Write_Strobe !== strb)
          stable_bad++;
      end
      if (R_Valid_Address === 1'b1) rva_n++;
      if (Read_Ready === 1'b1) rr_n++;
      if ((R_Valid_Address === 1'b1 || Read_Ready === 1'b1) && Read_Address_axi !== addr)
        stable_bad++;
      if (W_Prot !== 3'b000 || R_Prot !== 3'b000) stable_bad++;
      if (Write_Valid === 1'b1 && (R_Valid_Address === 1'b1 || Read_Ready === 1'b1))
        overlap_bad++;
      if (rsp_valid === 1'b1) begin
        rsp_n++;
        if (rsp_k == 0) begin
          rsp_k = k; got_rdata = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
        end
      end else if (rsp_k == 0 && (cmd_ready !== 1'b0 || busy !== 1'b1)) begin
        busy_bad++;
      end

      // Slave: answer inside the handshake, random noise outside it.
      if (Write_Valid === 1'b1) begin
        Write_Ready = wr && (strb == 4'hF) && (wv_n - 1 == d1);
        W_Error     = serr;
      end else begin
        Write_Ready = 1'($urandom);
        W_Error     = 1'($urandom);
      end
      if (R_Valid_Address === 1'b1) R_Ready_Address = (rva_n - 1 == d1);
      else                          R_Ready_Address = 1'($urandom);
      if (Read_Ready === 1'b1 && rr_n - 1 == d2) begin
        Valid_Data_R = 1'b1; Read_Data_axi = sdata; R_Error = serr;
      end else begin
        Valid_Data_R  = (Read_Ready === 1'b1) ? 1'b0 : 1'($urandom);
        Read_Data_axi = $urandom;
        R_Error       = 1'($urandom);
      end
      if (rsp_k > 0 && (hold || k > rsp_k)) break;
    end

    n_checks++;
    if (rsp_k !== exp_lat) begin
      n_fail++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, rsp_k, exp_lat);
    end
    n_checks++;
    if (got_rdata !== exp_rdata) begin
      n_fail++;
      $display("[TB] FAIL %s rsp_rdata: got %h, expected %h", name, got_rdata, exp_rdata);
    end
    n_checks++;
    if (got_err !== exp_err || got_to !== exp_to) begin
      n_fail++;
      $display("[TB] FAIL %s err/timeout: got %b/%b, expected %b/%b", name, got_err, got_to, exp_err, exp_to);
    end
    n_checks++;
    if (wv_n != exp_wv || rva_n != exp_rva || rr_n != exp_rr) begin
      n_fail++;
      $display("[TB] FAIL %s handshake cycles wv/rva/rr: got %0d/%0d/%0d, expected %0d/%0d/%0d",
               name, wv_n, rva_n, rr_n, exp_wv, exp_rva, exp_rr);
    end
    n_checks++;
    if (stable_bad != 0 || overlap_bad != 0 || busy_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL %s bus integrity: stable=%0d overlap=%0d busy=%0d bad cycles, expected 0",
               name, stable_bad, overlap_bad, busy_bad);
    end
    if (!hold) begin
      n_checks++;
      if (rsp_n != 1) begin
        n_fail++;
        $display("[TB] FAIL %s rsp_valid width: got %0d cycles, expected 1", name, rsp_n);
      end
    end
  endtask

  task automatic test_reset;
    #1 Rst = 1'b0;
    #2;
    n_checks++;
    if ({cmd_ready, busy, rsp_valid, rsp_err, rsp_timeout, Write_Valid, R_Valid_Address, Read_Ready} !== 8'b1000_0000) begin
      n_fail++;
      $display("[TB] FAIL reset control: got %b, expected 10000000",
               {cmd_ready, busy, rsp_valid, rsp_err, rsp_timeout, Write_Valid, R_Valid_Address, Read_Ready});
    end
    n_checks++;
    if ((rsp_rdata | Write_Address_axi | Write_Data_axi | Read_Address_axi) !== 32'h0 || Write_Strobe !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL reset data: rdata=%h waddr=%h wdata=%h raddr=%h strb=%h, expected all 0",
               rsp_rdata, Write_Address_axi, Write_Data_axi, Read_Address_axi, Write_Strobe);
    end
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_write_basic;
    run_txn("write_basic", 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_read_delayed;
    run_txn("read_delayed", 1'b0, 32'h0000_0120, 32'h0, 4'hF, 2, 3, 1'b0, 32'h0000_005A);
  endtask

  task automatic test_write_timeout;
    run_txn("write_timeout", 1'b1, 32'h0000_0040, 32'hCAFE_0001, 4'b0011, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_timeout_edge;
    run_txn("write_last_cycle", 1'b1, 32'h0000_0044, 32'h1111_2222, 4'hF, 254, 0, 1'b0, 32'h0);
    run_txn("read_timeout_span", 1'b0, 32'h0000_0048, 32'h0, 4'hF, 100, 200, 1'b0, 32'h7777_7777);
  endtask

  task automatic test_read_error;
    run_txn("read_error", 1'b0, 32'h0000_0130, 32'h0, 4'hF, 0, 0, 1'b1, 32'h1234_5678);
  endtask

  task automatic test_back_to_back;
    hold_en   = 1'b1;
    hold_addr = 32'h0000_0200;
    run_txn("b2b_write", 1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 4'hF, 1, 0, 1'b0, 32'h0);
    hold_en = 1'b0;
    run_txn("b2b_read", 1'b0, 32'h0000_0200, 32'hA5A5_5A5A, 4'hF, 0, 1, 1'b0, 32'hBEEF_0200);
    n_checks++;
    if (last_wait != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b accept gap: waited %0d cycles after response, expected 0", last_wait);
    end
  endtask

  task automatic test_reset_mid_read;
    int bad;
    bad = 0;
    Write_Ready = 1'b0; R_Ready_Address = 1'b1; Valid_Data_R = 1'b0;
    cmd_write = 1'b0; cmd_addr = 32'h0000_0300; cmd_valid = 1'b1;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    n_checks++;
    if (Read_Ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_read setup: Read_Ready=%b, expected 1", Read_Ready);
    end
    #2 Rst = 1'b0;
    #1;
    n_checks++;
    if ({R_Valid_Address, Read_Ready, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_read immediate: got %b, expected 00001",
               {R_Valid_Address, Read_Ready, rsp_valid, busy, cmd_ready});
    end
    @(negedge Clk);
    Rst = 1'b1;
    Valid_Data_R = 1'b1; Read_Data_axi = 32'hFFFF_0000; R_Error = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    Valid_Data_R = 1'b0; R_Ready_Address = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_read stray data: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_random;
    bit          wr, serr;
    logic [3:0]  strb;
    int          d1, d2;
    for (int i = 0; i < 24; i++) begin
      wr   = 1'($urandom);
      d1   = $urandom_range(0, 4);
      d2   = $urandom_range(0, 4);
      strb = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      serr = ($urandom_range(0, 3) == 0);
      run_txn($sformatf("random_%0d", i), wr, $urandom, $urandom, strb, d1, d2, serr, $urandom);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    Write_Ready = 1'b0; W_Error = 1'b0; R_Ready_Address = 1'b0;
    Valid_Data_R = 1'b0; Read_Data_axi = '0; R_Error = 1'b0;
    test_reset;
    test_write_basic;
    test_read_delayed;
    test_write_timeout;
    test_read_error;
    test_timeout_edge;
    test_back_to_back;
    test_reset_mid_read;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
